// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the memory-controller address path.
package memory_controller_pkg;

    // Field widths, MSB to LSB order within the mapped address.
    localparam int CHWIDTH  = 1;
    localparam int RKWIDTH  = 2;
    localparam int BGWIDTH  = 2;
    localparam int BKWIDTH  = 2;
    localparam int ROWWIDTH = 15;
    localparam int COLWIDTH = 10;

    localparam int MEMADDR_BITS = CHWIDTH + RKWIDTH + BGWIDTH + BKWIDTH + ROWWIDTH + COLWIDTH;
    localparam int IDXWIDTH     = CHWIDTH + RKWIDTH;

    // Address mapping modes.
    localparam int MAP_FIXED    = 0;
    localparam int MAP_XOR_BANK = 1;

    // Member order matches the slicing order, so a plain cast performs the fixed mapping.
    typedef struct packed {
        logic [CHWIDTH-1:0]  channel;
        logic [RKWIDTH-1:0]  rank;
        logic [BGWIDTH-1:0]  bankgroup;
        logic [BKWIDTH-1:0]  bank;
        logic [ROWWIDTH-1:0] row;
        logic [COLWIDTH-1:0] col;
    } MemoryAddress;

endpackage

// File: rtl/address_decoder.sv
// Combinational address split into channel/rank/bankgroup/bank/row/col, with
// optional XOR bank hashing. Channel and rank never change, so the FSM index is
// the same in both mapping modes.
module address_decoder
    import memory_controller_pkg::*;
#(
    parameter int AXI_ADDRWIDTH = 32,
    parameter int MEM_ADDRWIDTH = MEMADDR_BITS,
    parameter int MAP_MODE      = MAP_FIXED
) (
    input  logic [AXI_ADDRWIDTH-1:0] addr_i,
    output MemoryAddress             mem_addr_o,
    output logic [IDXWIDTH-1:0]      index_o
);

    // Slice the low address bits and optionally fold the low row bits into bank/bankgroup.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no latch can be inferred.
        mem_addr_o = MemoryAddress'(addr_i[MEM_ADDRWIDTH-1:0]);
        if (MAP_MODE == MAP_XOR_BANK) begin
            mem_addr_o.bank      = mem_addr_o.bank ^ mem_addr_o.row[BKWIDTH-1:0];
            mem_addr_o.bankgroup = mem_addr_o.bankgroup ^ mem_addr_o.row[BKWIDTH +: BGWIDTH];
        end
    end

    assign index_o = {mem_addr_o.channel, mem_addr_o.rank};

endmodule

// File: rtl/address_translation_stage.sv
// Read/write address arbiter with write-starvation bound, decode, and a
// one-entry output register held until the target execution FSM accepts it.
module address_translation_stage
    import memory_controller_pkg::*;
#(
    parameter int AXI_ADDRWIDTH              = 32,
    parameter int MEM_ADDRWIDTH              = MEMADDR_BITS,
    parameter int NUM_RANKEXECUTION_UNIT     = 2 ** (CHWIDTH + RKWIDTH),
    parameter int NUM_RANKEXECUTION_UNIT_BIT = $clog2(NUM_RANKEXECUTION_UNIT),
    parameter int MAP_MODE                   = MAP_FIXED,
    parameter int WR_STARVE_LIMIT            = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [AXI_ADDRWIDTH-1:0]              readAddr,
    input  logic                                  readValid,
    output logic                                  readReady,
    input  logic [AXI_ADDRWIDTH-1:0]              writeAddr,
    input  logic                                  writeValid,
    output logic                                  writeReady,
    input  logic [NUM_RANKEXECUTION_UNIT-1:0]     fsmReady,
    output logic                                  outValid,
    output logic                                  outIsWrite,
    output logic [NUM_RANKEXECUTION_UNIT_BIT-1:0] targetFSMIndex,
    output logic [NUM_RANKEXECUTION_UNIT-1:0]     targetFSMVector,
    output MemoryAddress                          requestMemAddr
);

    localparam int STARVE_W = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(WR_STARVE_LIMIT);

    MemoryAddress                          rd_mem, wr_mem;
    logic [NUM_RANKEXECUTION_UNIT_BIT-1:0] rd_idx, wr_idx;

    logic                                  out_valid_q, out_valid_d;
    logic                                  out_is_write_q, out_is_write_d;
    logic [NUM_RANKEXECUTION_UNIT_BIT-1:0] out_idx_q, out_idx_d;
    MemoryAddress                          out_addr_q, out_addr_d;
    logic [STARVE_W-1:0]                   starve_q, starve_d;

    logic out_accept, can_load, read_grant, write_grant;

    address_decoder #(
        .AXI_ADDRWIDTH(AXI_ADDRWIDTH),
        .MEM_ADDRWIDTH(MEM_ADDRWIDTH),
        .MAP_MODE     (MAP_MODE)
    ) u_rd_decoder (
        .addr_i    (readAddr),
        .mem_addr_o(rd_mem),
        .index_o   (rd_idx)
    );

    address_decoder #(
        .AXI_ADDRWIDTH(AXI_ADDRWIDTH),
        .MEM_ADDRWIDTH(MEM_ADDRWIDTH),
        .MAP_MODE     (MAP_MODE)
    ) u_wr_decoder (
        .addr_i    (writeAddr),
        .mem_addr_o(wr_mem),
        .index_o   (wr_idx)
    );

    assign out_accept = out_valid_q & fsmReady[out_idx_q];
    assign can_load   = ~out_valid_q | out_accept;

    // Arbitration: reads first unless a write has waited through the full starvation budget.
    always_comb begin
        write_grant = 1'b0;
        read_grant  = 1'b0;
        if (can_load && !rst) begin
            if (writeValid && (!readValid || starve_q == STARVE_MAX)) begin
                write_grant = 1'b1;
            end else if (readValid) begin
                read_grant = 1'b1;
            end
        end
    end

    assign readReady  = read_grant;
    assign writeReady = write_grant;

    // Count consecutive read grants that bypass a waiting write, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!writeValid || write_grant) begin
            starve_d = '0;
        end else if (read_grant && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Output register: load on a grant, otherwise drain on accept, otherwise hold.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_is_write_d = out_is_write_q;
        out_idx_d      = out_idx_q;
        out_addr_d     = out_addr_q;
        if (write_grant) begin
            out_valid_d    = 1'b1;
            out_is_write_d = 1'b1;
            out_idx_d      = wr_idx;
            out_addr_d     = wr_mem;
        end else if (read_grant) begin
            out_valid_d    = 1'b1;
            out_is_write_d = 1'b0;
            out_idx_d      = rd_idx;
            out_addr_d     = rd_mem;
        end else if (out_accept) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset clears the held request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the payload registers are reset too, because the held address and index are visible outputs that must read 0 in reset.
            out_valid_q    <= 1'b0;
            out_is_write_q <= 1'b0;
            out_idx_q      <= '0;
            out_addr_q     <= '0;
            starve_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            out_valid_q    <= out_valid_d;
            out_is_write_q <= out_is_write_d;
            out_idx_q      <= out_idx_d;
            out_addr_q     <= out_addr_d;
            starve_q       <= starve_d;
        end
    end

    // One-hot target select, silent when nothing is held.
    always_comb begin
        targetFSMVector = '0;
        if (out_valid_q) begin
            targetFSMVector[out_idx_q] = 1'b1;
        end
    end

    assign outValid       = out_valid_q;
    assign outIsWrite     = out_is_write_q;
    assign targetFSMIndex = out_idx_q;
    assign requestMemAddr = out_addr_q;

endmodule

// File: tb/tb_address_translation_stage.sv
// Bench for address_translation_stage: a fixed-mapping and an XOR-mapping
// instance share one stimulus; a queue scoreboard checks every delivered request.
module tb_address_translation_stage;
    import memory_controller_pkg::*;

    logic        clk, rst;
    logic [31:0] readAddr, writeAddr;
    logic        readValid, writeValid;
    logic [7:0]  fsmReady;

    logic         readReady, writeReady, outValid, outIsWrite;
    logic [2:0]   targetFSMIndex;
    logic [7:0]   targetFSMVector;
    MemoryAddress requestMemAddr;

    logic         x_readReady, x_writeReady, x_outValid, x_outIsWrite;
    logic [2:0]   x_targetFSMIndex;
    logic [7:0]   x_targetFSMVector;
    MemoryAddress x_requestMemAddr;

    address_translation_stage #(.MAP_MODE(MAP_FIXED), .WR_STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .readAddr(readAddr), .readValid(readValid), .readReady(readReady),
        .writeAddr(writeAddr), .writeValid(writeValid), .writeReady(writeReady),
        .fsmReady(fsmReady), .outValid(outValid), .outIsWrite(outIsWrite),
        .targetFSMIndex(targetFSMIndex), .targetFSMVector(targetFSMVector),
        .requestMemAddr(requestMemAddr)
    );

    address_translation_stage #(.MAP_MODE(MAP_XOR_BANK), .WR_STARVE_LIMIT(8)) dut_x (
        .clk(clk), .rst(rst),
        .readAddr(readAddr), .readValid(readValid), .readReady(x_readReady),
        .writeAddr(writeAddr), .writeValid(writeValid), .writeReady(x_writeReady),
        .fsmReady(fsmReady), .outValid(x_outValid), .outIsWrite(x_outIsWrite),
        .targetFSMIndex(x_targetFSMIndex), .targetFSMVector(x_targetFSMVector),
        .requestMemAddr(x_requestMemAddr)
    );

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
    } sb_item_t;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        wv;
        logic [31:0] wa;
        logic [7:0]  fr;
        logic        exp_rr;
        logic        exp_wr;
    } vec_t;

    sb_item_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, written against absolute bit positions.
    function automatic MemoryAddress model(input logic [31:0] a, input bit xor_mode);
        MemoryAddress m;
        m.channel   = a[31];
        m.rank      = a[30:29];
        m.bankgroup = a[28:27];
        m.bank      = a[26:25];
        m.row       = a[24:10];
        m.col       = a[9:0];
        if (xor_mode) begin
            m.bank      = m.bank ^ a[11:10];
            m.bankgroup = m.bankgroup ^ a[13:12];
        end
        return m;
    endfunction

    // Scoreboard monitor: whatever is held must match the queue head; pop on accept.
    always @(negedge clk) begin
        if (!rst && outValid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_out", 64'(outValid), 64'(0));
            end else begin
                sb_item_t    it;
                logic [7:0]  one;
                logic [2:0]  eidx;
                it   = sb_q[0];
                one  = 8'd1;
                eidx = it.addr[31:29];
                check("sb_is_write", 64'(outIsWrite), 64'(it.is_write));
                check("sb_index", 64'(targetFSMIndex), 64'(eidx));
                check("sb_vector", 64'(targetFSMVector), 64'(one << eidx));
                check("sb_addr_fixed", 64'(requestMemAddr), 64'(model(it.addr, 1'b0)));
                check("sb_addr_xor", 64'(x_requestMemAddr), 64'(model(it.addr, 1'b1)));
                if (fsmReady[targetFSMIndex]) void'(sb_q.pop_front());
            end
        end
    end

    // One cycle: drive after the edge, check handshakes at the falling edge, log grants.
    task automatic step(input logic rv, input logic [31:0] ra, input logic wv,
                        input logic [31:0] wa, input logic [7:0] fr,
                        input logic err, input logic ewr, input string tag);
        @(posedge clk);
        #1;
        readValid  = rv;
        readAddr   = ra;
        writeValid = wv;
        writeAddr  = wa;
        fsmReady   = fr;
        @(negedge clk);
        check({tag, "_readReady"}, 64'(readReady), 64'(err));
        check({tag, "_writeReady"}, 64'(writeReady), 64'(ewr));
        check({tag, "_x_readReady"}, 64'(x_readReady), 64'(err));
        if (err) sb_q.push_back('{is_write: 1'b0, addr: ra});
        if (ewr) sb_q.push_back('{is_write: 1'b1, addr: wa});
    endtask

    task automatic idle(input string tag);
        step(1'b0, 32'h0, 1'b0, 32'h0, 8'hFF, 1'b0, 1'b0, tag);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'hC000_0003, 1'b1, 32'h5555_AAAA, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 32'h5555_AAAA, 8'hFF, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 32'h0,         8'hFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h4000_0400, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h2AAA_5555, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h0,         1'b1, 32'h1234_5678, 8'hFF, 1'b0, 1'b1};

        // Reset: requests present, nothing accepted, all outputs zero.
        rst = 1'b1;
        readValid = 1'b1; readAddr = 32'h8000_0000;
        writeValid = 1'b1; writeAddr = 32'hFFFF_FFFF;
        fsmReady = 8'hFF;
        @(negedge clk);
        check("rst_readReady", 64'(readReady), 64'(0));
        check("rst_writeReady", 64'(writeReady), 64'(0));
        check("rst_outValid", 64'(outValid), 64'(0));
        check("rst_outIsWrite", 64'(outIsWrite), 64'(0));
        check("rst_index", 64'(targetFSMIndex), 64'(0));
        check("rst_vector", 64'(targetFSMVector), 64'(0));
        check("rst_addr", 64'(requestMemAddr), 64'(0));
        readValid = 1'b0; writeValid = 1'b0;
        #2 rst = 1'b0;

        // Single read to channel 1: visible one cycle later, gone the cycle after.
        step(1'b1, 32'h8000_0000, 1'b0, 32'h0, 8'hFF, 1'b1, 1'b0, "first_rd");
        idle("first_rd_out");
        check("first_rd_outValid", 64'(outValid), 64'(1));
        check("first_rd_channel", 64'(requestMemAddr.channel), 64'(1));
        check("first_rd_rank", 64'(requestMemAddr.rank), 64'(0));
        check("first_rd_index", 64'(targetFSMIndex), 64'(4));
        check("first_rd_vector", 64'(targetFSMVector), 64'(8'h10));
        check("first_rd_isWrite", 64'(outIsWrite), 64'(0));
        idle("first_rd_drain");
        check("first_rd_outValid_clear", 64'(outValid), 64'(0));

        // XOR hashing on bank/bankgroup, row untouched.
        step(1'b1, 32'h1200_1C00, 1'b0, 32'h0, 8'hFF, 1'b1, 1'b0, "xor_rd");
        idle("xor_out");
        check("xor_bank", 64'(x_requestMemAddr.bank), 64'(2'b10));
        check("xor_bankgroup", 64'(x_requestMemAddr.bankgroup), 64'(2'b11));
        check("xor_row", 64'(x_requestMemAddr.row), 64'(15'h0007));
        check("fixed_bank", 64'(requestMemAddr.bank), 64'(2'b01));
        idle("xor_drain");

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rv, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].fr,
                 vecs[i].exp_rr, vecs[i].exp_wr, $sformatf("vec%0d", i));
        end
        idle("vec_drain");

        // Both valid: eight reads, then the starved write, then reads resume.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom(), 1'b1, $urandom(), 8'hFF,
                 (i % 9) != 8, (i % 9) == 8, $sformatf("starve%0d", i));
        end
        idle("starve_drain");
        idle("starve_drain2");

        // Head-of-line hold: target FSM 1 busy for five cycles, others ready.
        step(1'b1, 32'h2000_0000, 1'b0, 32'h0, 8'hFD, 1'b1, 1'b0, "hold_a");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h6000_0010, 1'b1, 32'hA000_0020, 8'hFD, 1'b0, 1'b0, $sformatf("hold%0d", i));
            check("hold_outValid", 64'(outValid), 64'(1));
            check("hold_index", 64'(targetFSMIndex), 64'(1));
            check("hold_vector", 64'(targetFSMVector), 64'(8'h02));
        end
        step(1'b1, 32'h6000_0010, 1'b1, 32'hA000_0020, 8'hFF, 1'b1, 1'b0, "hold_release");
        step(1'b0, 32'h0, 1'b1, 32'hA000_0020, 8'hFF, 1'b0, 1'b1, "hold_write");
        idle("hold_drain");
        idle("hold_drain2");

        // Back-to-back reads alternating between FSM 0 and FSM 7.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = (i % 2 == 1) ? (32'hE000_0000 | 32'(i)) : (32'(i) << 10);
            step(1'b1, a, 1'b0, 32'h0, 8'hFF, 1'b1, 1'b0, $sformatf("b2b%0d", i));
            if (i > 0) check("b2b_no_bubble", 64'(outValid), 64'(1));
        end
        idle("b2b_drain");
        idle("b2b_drain2");

        // Reset in the middle of a held write clears everything asynchronously.
        step(1'b0, 32'h0, 1'b1, 32'hE000_1234, 8'h00, 1'b0, 1'b1, "rst_wr");
        step(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, "rst_hold");
        check("rst_pre_outValid", 64'(outValid), 64'(1));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_outValid", 64'(outValid), 64'(0));
        check("midrst_outIsWrite", 64'(outIsWrite), 64'(0));
        check("midrst_index", 64'(targetFSMIndex), 64'(0));
        check("midrst_vector", 64'(targetFSMVector), 64'(0));
        check("midrst_addr", 64'(requestMemAddr), 64'(0));
        check("midrst_x_addr", 64'(x_requestMemAddr), 64'(0));
        sb_q.delete();
        #3 rst = 1'b0;
        step(1'b1, 32'h4000_0000, 1'b0, 32'h0, 8'hFF, 1'b1, 1'b0, "post_rst");
        idle("post_rst_out");
        check("post_rst_outValid", 64'(outValid), 64'(1));
        check("post_rst_index", 64'(targetFSMIndex), 64'(2));
        idle("post_rst_drain");

        check("sb_empty_at_end", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
